// File: rtl/cnt_mod_ctrl_pkg.sv
// cnt_mod_ctrl shared types and helpers.
// State encoding and index utilities.
package cnt_mod_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int oh2idx(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_mod_ctrl_if.sv
// cnt_mod_ctrl request / counter bus.
// master = requester side, slave = controller.
interface cnt_mod_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int REQS  = 4,
  parameter int IDW   = 2
);
  logic             en;
  logic [REQS-1:0]  req;
  logic [REQS-1:0]  gnt;
  logic             busy;
  logic             cnt_ce;
  logic             cnt_rst;
  logic [WIDTH-1:0] cnt_out;
  logic             done;
  logic [IDW-1:0]   done_id;

  modport master (
    output en, req, cnt_out,
    input  gnt, busy, cnt_ce, cnt_rst,
    input  done, done_id
  );

  modport slave (
    input  en, req, cnt_out,
    output gnt, busy, cnt_ce, cnt_rst,
    output done, done_id
  );
endinterface

// File: rtl/cnt_mod_ctrl_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Scans last+1, last+2, ... with wrap.
module rr_arbiter #(
  parameter int REQS = 4,
  parameter int IDW  = 2
) (
  input  logic [REQS-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [REQS-1:0] win
);

  int w_best;
  int w_pos;
  int w_d;

  // pick the requester at the smallest rotated distance from last
  always_comb begin
    w_best = REQS;
    w_pos  = 0;
    w_d    = 0;
    for (int p = 0; p < REQS; p++) begin
      w_d = (p + REQS - 1 - int'(last)) % REQS;
      if (req[p] && (w_d < w_best)) begin
        w_best = w_d;
        w_pos  = p;
      end
    end
    win = '0;
    for (int p = 0; p < REQS; p++) begin
      win[p] = (w_best < REQS) && (w_pos == p);
    end
  end

endmodule

// File: rtl/cnt_mod_ctrl.sv
// Shares one modulo counter among REQS requesters.
// Grant, clear, run one period, pulse done.
module cnt_mod_ctrl
  import cnt_mod_ctrl_pkg::*;
#(
  parameter int MODULO = 7,
  parameter int WIDTH  = $clog2(MODULO),
  parameter int REQS   = 4,
  parameter int IDW    = idw_of(REQS)
) (
  input logic          clk,
  input logic          rst,
  cnt_mod_ctrl_if.slave bus
);

  state_t          r_state;
  logic [REQS-1:0] r_gnt;
  logic [IDW-1:0]  r_last;
  logic            r_busy;
  logic            r_run;
  logic            r_cnt_rst;
  logic            r_done;
  logic [IDW-1:0]  r_done_id;

  logic [REQS-1:0] w_win;
  logic [IDW-1:0]  w_win_idx;
  logic            w_any;
  logic            w_keep;
  logic            w_wrap;

  rr_arbiter #(
    .REQS (REQS),
    .IDW  (IDW)
  ) u_arb (
    .req  (bus.req),
    .last (r_last),
    .win  (w_win)
  );

  assign w_any     = |bus.req;
  assign w_keep    = |(bus.req & r_gnt);
  assign w_wrap    = bus.en &&
                     (bus.cnt_out == WIDTH'(MODULO - 1));
  assign w_win_idx = IDW'(oh2idx(32'(w_win)));

  // controller FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_last    <= IDW'(REQS - 1);
      r_busy    <= 1'b0;
      r_run     <= 1'b0;
      r_cnt_rst <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_any) begin
            r_state   <= ST_CLEAR;
            r_gnt     <= w_win;
            r_last    <= w_win_idx;
            r_busy    <= 1'b1;
            r_cnt_rst <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_cnt_rst <= 1'b0;
          if (!w_keep) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_keep) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_run   <= 1'b0;
          end else if (w_wrap) begin
            r_state   <= ST_DONE;
            r_gnt     <= '0;
            r_run     <= 1'b0;
            r_done    <= 1'b1;
            r_done_id <= r_last;
          end
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.cnt_rst = r_cnt_rst;
  assign bus.cnt_ce  = r_run & bus.en;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;

endmodule

// File: tb/tb_cnt_mod_ctrl.sv
// Scoreboard bench for cnt_mod_ctrl.
// Includes a behavioural modulo counter.
module tb_cnt_mod_ctrl;
  import cnt_mod_ctrl_pkg::*;

  localparam int MODULO = 7;
  localparam int WIDTH  = 3;
  localparam int REQS   = 4;
  localparam int IDW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnt_mod_ctrl_if #(
    .WIDTH (WIDTH),
    .REQS  (REQS),
    .IDW   (IDW)
  ) ifc ();

  cnt_mod_ctrl #(
    .MODULO (MODULO),
    .WIDTH  (WIDTH),
    .REQS   (REQS),
    .IDW    (IDW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [WIDTH-1:0] r_cnt = '0;
  always @(posedge clk) begin
    if (ifc.cnt_rst) r_cnt <= '0;
    else if (ifc.cnt_ce)
      r_cnt <= (r_cnt == WIDTH'(MODULO - 1)) ?
               '0 : r_cnt + 1'b1;
  end
  assign ifc.cnt_out = r_cnt;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int at;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_on   = 1'b1;
  int rand_done = 0;

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic at(int t);
    repeat (t - cyc) @(posedge clk);
    #1;
  endtask

  task automatic expect_done(int id, int t);
    exp_t e;
    e.id = id;
    e.at = t;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // monitor: invariants, grant tenure and done scoreboard
  logic [REQS-1:0] t_gnt = '0;
  int t_ce = 0;
  bit t_ok = 1'b0;
  bit inv_ok;
  exp_t e_pop;
  always @(negedge clk) begin
    if (!rst) begin
      t_ok  = 1'b0;
      t_ce  = 0;
      t_gnt = '0;
    end else begin
      inv_ok = $onehot0(ifc.gnt) &&
               !(ifc.cnt_ce && ifc.cnt_rst) &&
               !(ifc.done && (ifc.gnt != '0));
      chk("invariant", int'(inv_ok), 1);
      if (ifc.done) begin
        chk("tenure_valid", int'(t_ok), 1);
        chk("tenure_ce", t_ce, MODULO);
        chk("tenure_id", int'(ifc.done_id),
            oh2idx(32'(t_gnt)));
        if (!sb_on) begin
          rand_done++;
        end else begin
          chk("sb_pending", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e_pop = q.pop_front();
            chk("done_id", int'(ifc.done_id), e_pop.id);
            chk("done_cycle", cyc, e_pop.at);
          end
        end
      end
      if (ifc.cnt_rst && (ifc.gnt != '0)) begin
        t_gnt = ifc.gnt;
        t_ce  = 0;
        t_ok  = 1'b1;
      end else if ((ifc.gnt == '0) || (ifc.gnt != t_gnt)) begin
        t_ok = 1'b0;
      end else if (ifc.cnt_ce) begin
        t_ce++;
      end
    end
  end

  int c;
  int d;

  initial begin
    ifc.req = '0;
    ifc.en  = 1'b1;
    rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", int'(ifc.gnt), 0);
    chk("rst_busy", int'(ifc.busy), 0);
    chk("rst_ce", int'(ifc.cnt_ce), 0);
    chk("rst_crst", int'(ifc.cnt_rst), 0);
    chk("rst_done", int'(ifc.done), 0);
    rst = 1'b1;
    at(cyc + 2);
    chk("idle_gnt", int'(ifc.gnt), 0);
    chk("idle_busy", int'(ifc.busy), 0);

    // single request from requester 0
    c = cyc;
    ifc.req = 4'b0001;
    expect_done(0, c + 9);
    at(c + 1);
    chk("t1_gnt", int'(ifc.gnt), 1);
    chk("t1_crst", int'(ifc.cnt_rst), 1);
    chk("t1_busy", int'(ifc.busy), 1);
    at(c + 2);
    chk("t1_crst_off", int'(ifc.cnt_rst), 0);
    chk("t1_cnt0", int'(ifc.cnt_out), 0);
    chk("t1_ce", int'(ifc.cnt_ce), 1);
    at(c + 8);
    chk("t1_cnt6", int'(ifc.cnt_out), 6);
    at(c + 9);
    chk("t1_done_gnt", int'(ifc.gnt), 0);
    ifc.req = '0;
    at(c + 11);
    chk("t1_idle", int'(ifc.busy), 0);

    // all four requesting: rotation 0,1,2,3,0
    do_reset();
    c = cyc;
    ifc.req = 4'b1111;
    for (int j = 0; j < 5; j++)
      expect_done(j % 4, c + 9 + 9 * j);
    for (int j = 0; j < 5; j++) begin
      at(c + 1 + 9 * j);
      chk("t2_gnt", int'(ifc.gnt), 1 << (j % 4));
    end
    at(c + 45);
    ifc.req = '0;
    at(c + 47);

    // stall at cnt_out=3 for 5 cycles
    do_reset();
    c = cyc;
    ifc.req = 4'b0100;
    expect_done(2, c + 14);
    at(c + 5);
    chk("t3_cnt3", int'(ifc.cnt_out), 3);
    ifc.en = 1'b0;
    at(c + 7);
    chk("t3_hold", int'(ifc.cnt_out), 3);
    chk("t3_gnt", int'(ifc.gnt), 4);
    chk("t3_ce_off", int'(ifc.cnt_ce), 0);
    at(c + 9);
    chk("t3_hold2", int'(ifc.cnt_out), 3);
    at(c + 10);
    ifc.en = 1'b1;
    at(c + 13);
    chk("t3_cnt6", int'(ifc.cnt_out), 6);
    at(c + 14);
    ifc.req = '0;
    at(c + 16);

    // abort of requester 1 with requester 3 pending
    c = cyc;
    ifc.req = 4'b0010;
    at(c + 1);
    chk("t4_gnt1", int'(ifc.gnt), 2);
    at(c + 6);
    chk("t4_cnt4", int'(ifc.cnt_out), 4);
    ifc.req = 4'b1000;
    at(c + 7);
    chk("t4_abort_gnt", int'(ifc.gnt), 0);
    chk("t4_abort_busy", int'(ifc.busy), 0);
    chk("t4_abort_done", int'(ifc.done), 0);
    ifc.req = 4'b1010;
    expect_done(3, c + 16);
    at(c + 8);
    chk("t4_gnt3", int'(ifc.gnt), 8);
    at(c + 16);
    ifc.req = '0;
    at(c + 18);

    // reset mid-run, pointer back to REQS-1
    c = cyc;
    ifc.req = 4'b0001;
    at(c + 4);
    chk("t5_run_ce", int'(ifc.cnt_ce), 1);
    rst = 1'b0;
    #1;
    chk("t5_gnt", int'(ifc.gnt), 0);
    chk("t5_busy", int'(ifc.busy), 0);
    chk("t5_ce", int'(ifc.cnt_ce), 0);
    chk("t5_crst", int'(ifc.cnt_rst), 0);
    chk("t5_done", int'(ifc.done), 0);
    ifc.req = 4'b0010;
    @(posedge clk);
    #1;
    rst = 1'b1;
    d = cyc;
    expect_done(1, d + 9);
    at(d + 1);
    chk("t5_gnt_after", int'(ifc.gnt), 2);
    at(d + 9);
    ifc.req = '0;
    at(d + 12);

    // random req/en, checked by the monitor
    sb_on = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 7) == 0)
        ifc.req = 4'($urandom_range(0, 15));
      ifc.en = ($urandom_range(0, 3) != 0);
    end
    ifc.req = '0;
    ifc.en  = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rand_dones", int'(rand_done > 0), 1);
    chk("sb_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
